// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan
//  Brief    : 4x4 active-low matrix keypad scanner. Walks a single low column
//             once per 1 ms tick, debounces a single-row press and its
//             release, and shifts accepted hex digits into a 32-bit word
//             (newest digit in [3:0]) for the 8-digit display.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scan #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int DEBOUNCE_MS   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] data,
  output logic [3:0]  digit_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int            MAX_COUNTER  = CLK_FREQUENCY / 1000;
  localparam int            c_cnt_w      = (MAX_COUNTER > 1) ? $clog2(MAX_COUNTER) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MAX_COUNTER - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [3:0]    c_deb_target = 4'(DEBOUNCE_MS);
  localparam logic [3:0]    c_rows_idle  = 4'b1111;
  localparam logic [3:0]    c_max_digits = 4'd8;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [3:0]         r_row_meta;
  logic [3:0]         r_row_s;

  logic [c_cnt_w-1:0] r_tick_cnt;
  logic               r_tick;

  state_t             r_state;
  logic [1:0]         r_col_idx;
  logic [3:0]         r_row_lat;
  logic [3:0]         r_deb_cnt;
  logic [3:0]         r_rel_cnt;

  state_t             w_state_nxt;
  logic [1:0]         w_col_idx_nxt;
  logic [3:0]         w_row_lat_nxt;
  logic [3:0]         w_deb_cnt_nxt;
  logic [3:0]         w_rel_cnt_nxt;
  logic               w_accept;

  logic [3:0]         w_row_low;
  logic               w_one_low;
  logic [1:0]         w_lat_idx;

  logic               r_key_valid;
  logic [3:0]         r_key_code;
  logic [31:0]        r_data;
  logic [3:0]         r_digit_count;

  logic [3:0]         w_col;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous row inputs (idle = all high)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_meta <= c_rows_idle;
      r_row_s    <= c_rows_idle;
    end else begin
      r_row_meta <= row;
      r_row_s    <= r_row_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Free-running 1 ms divider; r_tick pulses in the cycle after the wrap
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (r_tick_cnt == c_cnt_last) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_cnt_one;
      r_tick     <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Press qualification: exactly one row low; multiple lows are ghosting
  // --------------------------------------------------------------------------
  always_comb begin
    w_row_low = ~r_row_s;
    w_one_low = (w_row_low != 4'd0) && ((w_row_low & (w_row_low - 4'd1)) == 4'd0);
  end

  // Row index of the latched single-low pattern
  always_comb begin
    w_lat_idx = 2'd0;
    case (r_row_lat)
      4'b1110: w_lat_idx = 2'd0;
      4'b1101: w_lat_idx = 2'd1;
      4'b1011: w_lat_idx = 2'd2;
      4'b0111: w_lat_idx = 2'd3;
      default: w_lat_idx = 2'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM state register together with the column index and debounce counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_SCAN;
      r_col_idx <= 2'd0;
      r_row_lat <= c_rows_idle;
      r_deb_cnt <= 4'd0;
      r_rel_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_col_idx <= w_col_idx_nxt;
      r_row_lat <= w_row_lat_nxt;
      r_deb_cnt <= w_deb_cnt_nxt;
      r_rel_cnt <= w_rel_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: transitions only on a tick; disable forces a clean SCAN
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_col_idx_nxt = r_col_idx;
    w_row_lat_nxt = r_row_lat;
    w_deb_cnt_nxt = r_deb_cnt;
    w_rel_cnt_nxt = r_rel_cnt;
    w_accept      = 1'b0;

    if (!en) begin
      w_state_nxt   = ST_SCAN;
      w_col_idx_nxt = 2'd0;
      w_deb_cnt_nxt = 4'd0;
      w_rel_cnt_nxt = 4'd0;
    end else if (r_tick) begin
      case (r_state)
        ST_SCAN: begin
          if (w_one_low) begin
            w_row_lat_nxt = r_row_s;
            w_deb_cnt_nxt = 4'd0;
            w_state_nxt   = ST_DEBOUNCE;
          end else begin
            w_col_idx_nxt = r_col_idx + 2'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (r_row_s == r_row_lat) begin
            if ((r_deb_cnt + 4'd1) == c_deb_target) begin
              // Stable for the full window: accept and wait for release
              w_accept      = 1'b1;
              w_deb_cnt_nxt = 4'd0;
              w_rel_cnt_nxt = 4'd0;
              w_state_nxt   = ST_RELEASE;
            end else begin
              w_deb_cnt_nxt = r_deb_cnt + 4'd1;
            end
          end else begin
            // Pattern changed: rescan starting from the same column
            w_deb_cnt_nxt = 4'd0;
            w_state_nxt   = ST_SCAN;
          end
        end

        ST_RELEASE: begin
          if (r_row_s == c_rows_idle) begin
            if ((r_rel_cnt + 4'd1) == c_deb_target) begin
              w_rel_cnt_nxt = 4'd0;
              w_col_idx_nxt = r_col_idx + 2'd1;
              w_state_nxt   = ST_SCAN;
            end else begin
              w_rel_cnt_nxt = r_rel_cnt + 4'd1;
            end
          end else begin
            w_rel_cnt_nxt = 4'd0;
          end
        end

        default: begin
          w_state_nxt = ST_SCAN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Key event register: one-cycle pulse and code of the accepted key
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code <= {w_lat_idx, r_col_idx};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Digit shift register and saturating count; clear beats a same-cycle key
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data        <= 32'd0;
      r_digit_count <= 4'd0;
    end else if (clr) begin
      r_data        <= 32'd0;
      r_digit_count <= 4'd0;
    end else if (r_key_valid) begin
      r_data <= {r_data[27:0], r_key_code};
      if (r_digit_count != c_max_digits) begin
        r_digit_count <= r_digit_count + 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Column drive: one active-low column while enabled, all released otherwise
  // --------------------------------------------------------------------------
  always_comb begin
    w_col = 4'b1111;
    if (en) begin
      w_col = ~(4'b0001 << r_col_idx);
    end
  end

  assign col         = w_col;
  assign key_valid   = r_key_valid;
  assign key_code    = r_key_code;
  assign data        = r_data;
  assign digit_count = r_digit_count;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scan
//  Brief    : Directed self-checking bench for keypad_scan with a behavioural
//             4x4 keypad matrix model (8 clocks per scan tick, 4-tick debounce).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

  localparam int CLK_FREQUENCY = 8000;
  localparam int DEBOUNCE_MS   = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] data;
  logic [3:0]  digit_count;

  logic [15:0] pressed;   // bit r*4+c = key at row r / column c held down
  int          n_checks;
  int          n_fail;
  int          kv_pulses;
  int          p0;

  keypad_scan #(
    .CLK_FREQUENCY (CLK_FREQUENCY),
    .DEBOUNCE_MS   (DEBOUNCE_MS)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clr         (clr),
    .row         (row),
    .col         (col),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .data        (data),
    .digit_count (digit_count)
  );

  // 100 MHz nominal clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad matrix: a held key pulls its row low while its column is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && (col[c] == 1'b0)) begin
          row[r] = 1'b0;
        end
      end
    end
  end

  // Count key_valid pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      kv_pulses++;
    end
  end

  // Safety net against a hung run
  initial begin
    #800_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for a key_valid pulse; returns on the negedge it is seen
  task automatic wait_kv(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  // Wait (bounded) until a given column pattern is driven
  task automatic wait_col(input logic [3:0] want, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (col === want) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  // Press one key until accepted, hold briefly, release and let release settle
  task automatic press_key(input int k);
    pressed = 16'(1) << k;
    wait_kv(200, $sformatf("kv_key%0d", k));
    cycles(16);
    pressed = 16'd0;
    cycles(64);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    kv_pulses = 0;
    pressed   = 16'd0;
    en        = 1'b1;
    clr       = 1'b0;
    rst_n     = 1'b0;

    // ---- 1: reset values and column walk ----
    cycles(4);
    check("rst_col",       {28'd0, col},         32'hE);
    check("rst_data",      data,                 32'h0);
    check("rst_count",     {28'd0, digit_count}, 32'h0);
    check("rst_kv",        {31'd0, key_valid},   32'h0);
    check("rst_code",      {28'd0, key_code},    32'h0);
    rst_n = 1'b1;
    cycles(8);
    check("walk_col0",     {28'd0, col}, 32'hE);
    cycles(1);
    check("walk_col1",     {28'd0, col}, 32'hD);
    cycles(8);
    check("walk_col2",     {28'd0, col}, 32'hB);
    cycles(8);
    check("walk_col3",     {28'd0, col}, 32'h7);
    cycles(8);
    check("walk_wrap",     {28'd0, col}, 32'hE);

    // ---- 2: single press row1/col2 ----
    p0 = kv_pulses;
    pressed = 16'(1) << 6;
    wait_kv(200, "s2_kv");
    check("s2_code",       {28'd0, key_code}, 32'h6);
    cycles(30);
    check("s2_col_held",   {28'd0, col}, 32'hB);
    pressed = 16'd0;
    cycles(64);
    check("s2_one_pulse",  kv_pulses - p0, 32'd1);
    check("s2_data",       data, 32'h0000_0006);
    check("s2_count",      {28'd0, digit_count}, 32'h1);

    // ---- 3: bouncing row2/col2 then stable ----
    p0 = kv_pulses;
    repeat (6) begin
      pressed = 16'(1) << 10;
      cycles(16);
      pressed = 16'd0;
      cycles(16);
    end
    check("s3_no_kv_bounce", kv_pulses - p0, 32'd0);
    pressed = 16'(1) << 10;
    wait_kv(200, "s3_kv");
    check("s3_code",       {28'd0, key_code}, 32'hA);
    cycles(16);
    pressed = 16'd0;
    cycles(64);
    check("s3_one_pulse",  kv_pulses - p0, 32'd1);
    check("s3_data",       data, 32'h0000_006A);
    check("s3_count",      {28'd0, digit_count}, 32'h2);

    // ---- 4: overflow, saturation, ghost press ----
    for (int k = 1; k <= 9; k++) begin
      press_key(k);
    end
    check("s4_data",       data, 32'h2345_6789);
    check("s4_count",      {28'd0, digit_count}, 32'h8);
    p0 = kv_pulses;
    pressed = 16'h0011;
    cycles(100);
    check("s4_ghost_no_kv", kv_pulses - p0, 32'd0);
    pressed = 16'd0;
    cycles(64);
    check("s4_ghost_data", data, 32'h2345_6789);
    check("s4_ghost_count", {28'd0, digit_count}, 32'h8);

    // ---- 5: clr lands in the same cycle as key_valid ----
    pressed = 16'(1) << 5;
    wait_kv(200, "s5_kv");
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("s5_code",       {28'd0, key_code}, 32'h5);
    check("s5_data",       data, 32'h0);
    check("s5_count",      {28'd0, digit_count}, 32'h0);
    pressed = 16'd0;
    cycles(64);

    // ---- 6a: en dropped mid-debounce ----
    press_key(12);
    check("s6_pre_data",   data, 32'h0000_000C);
    check("s6_pre_count",  {28'd0, digit_count}, 32'h1);
    p0 = kv_pulses;
    pressed = 16'(1) << 3;
    wait_col(4'h7, 100, "s6_reach_col3");
    cycles(20);
    en = 1'b0;
    #1;
    check("s6_en_col",     {28'd0, col}, 32'hF);
    cycles(80);
    check("s6_en_no_kv",   kv_pulses - p0, 32'd0);
    check("s6_en_data",    data, 32'h0000_000C);
    check("s6_en_count",   {28'd0, digit_count}, 32'h1);
    check("s6_en_code",    {28'd0, key_code}, 32'hC);
    pressed = 16'd0;
    cycles(4);
    en = 1'b1;
    cycles(64);

    // ---- 6b: asynchronous reset mid-debounce ----
    p0 = kv_pulses;
    pressed = 16'(1) << 3;
    wait_col(4'h7, 100, "s6_reach_col3b");
    cycles(20);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_col",    {28'd0, col}, 32'hE);
    check("s6_rst_kv",     {31'd0, key_valid}, 32'h0);
    check("s6_rst_code",   {28'd0, key_code}, 32'h0);
    check("s6_rst_data",   data, 32'h0);
    check("s6_rst_count",  {28'd0, digit_count}, 32'h0);
    cycles(3);
    pressed = 16'd0;
    rst_n = 1'b1;
    cycles(100);
    check("s6_rst_discard", kv_pulses - p0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 active-low matrix keypad and assembles the pressed hex digits into a 32-bit word for the `led` display block. It is the input-side counterpart of the display driver: where `led` time-multiplexes its digit outputs, this block time-multiplexes its column drives and samples the rows. Its `data` output feeds `led.data` directly, so entered digits scroll in from the right on the 8-digit display.

## Interface

- `CLK_FREQUENCY`, default 100_000_000: clock rate in Hz. `MAX_COUNTER = CLK_FREQUENCY/1000` clocks per 1 ms scan tick.
- `DEBOUNCE_MS`, default 4: number of consecutive ticks needed to accept a press or a release (range 1–15).
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: enables scanning. When low, the columns are undriven and no key events occur.
- `clr` in 1: synchronous clear of `data` and `digit_count`.
- `row` in 4: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col` out 4: column drive, active-low, exactly one column low while scanning.
- `key_valid` out 1: one-cycle pulse per accepted key.
- `key_code` out 4: code of the last accepted key.
- `data` out 32: entered digits, newest digit in `[3:0]`.
- `digit_count` out 4: digits entered since reset or clear, saturating at 8.

## Operation

- **Row synchronizer:** two flops, reset value 4'b1111. All decisions use the synchronized `row_s`.
- **Tick counter:** counts 0..MAX_COUNTER-1 and wraps. `tick` is a registered one-cycle pulse in the cycle after the wrap, so the first tick comes MAX_COUNTER cycles after `rst_n` rises. The counter runs regardless of `en`.
- **Valid press:** exactly one bit of `row_s` is 0. Zero bits low, or two or more bits low (ghosting), counts as "no press".
- **`key_code`:** `row_idx*4 + col_idx`, where `row_idx` is the low `row_s` bit and `col_idx` is the driven column (col[0] low → col_idx 0).
- **FSM states:** SCAN, DEBOUNCE, RELEASE. All state changes happen only on a tick.
  - **SCAN:** `col = ~(1<<col_idx)`. On a tick, if there is a valid press, latch `row_s` and `col_idx`, clear `deb_cnt`, and go to DEBOUNCE. Otherwise advance `col_idx` by 1, wrapping from 3 to 0.
  - **DEBOUNCE:** the column is held. On a tick, if `row_s` equals the latched pattern, increment `deb_cnt`. When `deb_cnt` reaches DEBOUNCE_MS, accept the key and go to RELEASE. On a mismatch, go to SCAN with the same `col_idx`.
  - **RELEASE:** the column is held. On a tick with `row_s` == 4'b1111, increment `rel_cnt`; any low row clears `rel_cnt`. When `rel_cnt` reaches DEBOUNCE_MS, go to SCAN with `col_idx` advanced by 1.
- **Accept:** in the cycle after the accepting tick:
  - `key_valid` = 1 and `key_code` = the new code;
  - `data` <= `{data[27:0], key_code}`, so the oldest digit is lost once 8 digits are held;
  - `digit_count` <= min(`digit_count`+1, 8).
- **`en` low:** `col` = 4'b1111, the FSM is forced to SCAN with `col_idx` = 0, and counters are cleared. `data`, `key_code` and `digit_count` are retained.
- **`clr`:** `data` <= 0 and `digit_count` <= 0 on the next edge. If `clr` and an accept land on the same cycle, `clr` wins: `key_valid` and `key_code` still update, but `data` and `digit_count` become 0.
- **Auto-repeat:** none. Holding a key yields exactly one `key_valid`.

## Timing

- **Reset values:** `col` = 4'b1110, `key_valid` = 0, `key_code` = 0, `data` = 0, `digit_count` = 0; FSM in SCAN with `col_idx` = 0; tick counter = 0.
- **Column dwell:** 1 tick (1 ms) per column in SCAN; a full scan takes 4 ms.
- **Press latency:** about 2 cycles (synchronizer) plus up to 4 ticks to reach the column, 1 tick to detect, DEBOUNCE_MS ticks to accept, and 1 cycle to output.
- **Release:** a press can only be re-detected at least DEBOUNCE_MS ticks after the release begins.
- **`rst_n` assertion mid-debounce:** all outputs return to their reset values immediately (asynchronous), and the pending key is discarded.
- **Row glitch:** a glitch shorter than one tick that falls between ticks is invisible. One that is present on a tick in DEBOUNCE restarts the scan.

## Test plan

Use `CLK_FREQUENCY` = 8000 (8 clocks per tick) and `DEBOUNCE_MS` = 4 for all scenarios.

1. **Reset:** hold `rst_n` low with `row` = 4'hF → `col` = 4'b1110, `data` = 0, `digit_count` = 0, `key_valid` = 0. After release, `col` steps 1110→1101→1011→0111→1110, once every 8 clocks.
2. **Single press:** model press row1/col2 (`row[1]` low while col[2] low), held 10 ms → exactly one `key_valid`, `key_code` = 6, `data` = 32'h00000006, `digit_count` = 1. `col` stays 4'b1011 until the release is debounced.
3. **Bounce:** toggle `row[2]` on col2 every 2 ticks, then hold stable → no `key_valid` during toggling, then one pulse with `key_code` = 10. Starting from scenario 2, `data` = 32'h0000006A.
4. **Overflow and saturation:** enter 9 keys 1..9 → `data` = 32'h23456789, `digit_count` = 8; the ghost press (rows 0 and 1 both low) produces no event.
5. **`clr` collision:** assert `clr` in the same cycle as `key_valid` for key 5 → `key_code` = 5, `data` = 0, `digit_count` = 0.
6. **`en` and reset mid-operation:** drop `en` mid-debounce → `col` = 4'hF and no event, with `data` unchanged. Then pulse `rst_n` low mid-DEBOUNCE → all outputs return to their reset values asynchronously.
